// File: rtl/layer_sequencer.sv
// Sequences NL layer engines in order via start/end handshakes and muxes the
// shared activation RAM ports to the granted layer; adds watchdog and abort.
module layer_sequencer #(
  parameter int unsigned NL      = 4,
  parameter int unsigned LW      = 2,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 8,
  parameter int unsigned TW      = 20,
  parameter int unsigned TIMEOUT = 20'hFFFFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [LW-1:0]    err_layer_o,
  output logic [LW-1:0]    cur_layer_o,
  output logic [NL-1:0]    layer_start_o,
  input  logic [NL-1:0]    layer_end_i,
  input  logic [NL*AW-1:0] ram_addr_w_i,
  input  logic [NL*DW-1:0] ram_data_w_i,
  input  logic [NL-1:0]    ram_en_i,
  input  logic [NL-1:0]    ram_wea_i,
  input  logic [NL*AW-1:0] ram_addr_r_i,
  input  logic [NL-1:0]    ram_en_r_i,
  output logic [AW-1:0]    ram_addr_w_o,
  output logic [DW-1:0]    ram_data_w_o,
  output logic             ram_en_o,
  output logic             ram_wea_o,
  output logic [AW-1:0]    ram_addr_r_o,
  output logic             ram_en_r_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_RUN, S_DRAIN, S_DONE, S_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   k_q, k_d;
  logic            grant_q, grant_d;
  logic [TW-1:0]   wdog_q, wdog_d;
  logic [NL-1:0]   start_q, start_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [LW-1:0]   err_layer_q, err_layer_d;
  logic            end_sel;
  logic            wd_fire;

  // Next-state, watchdog and registered-output decode
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    grant_d     = grant_q;
    wdog_d      = wdog_q;
    end_sel     = layer_end_i[k_q];
    wd_fire     = (TIMEOUT != 0) && (wdog_q == TW'(TIMEOUT - 1));

    if (abort_i) begin
      state_d = S_IDLE;
      grant_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (run_i) begin
            state_d = S_START;
            k_d     = '0;
            grant_d = 1'b1;
          end
        end
        S_START: begin
          state_d = S_RUN;
          wdog_d  = '0;
        end
        S_RUN, S_DRAIN: begin
          if (wdog_q != '1) wdog_d = wdog_q + TW'(1);
          if (wd_fire) begin
            state_d = S_ERR;
            grant_d = 1'b0;
          end else if (state_q == S_RUN) begin
            if (end_sel) state_d = S_DRAIN;
          end else if (!end_sel) begin
            if (k_q == LW'(NL - 1)) begin
              state_d = S_DONE;
            end else begin
              k_d     = k_q + LW'(1);
              state_d = S_START;
            end
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          grant_d = 1'b0;
        end
        S_ERR: state_d = S_ERR;
        default: begin
          state_d = S_IDLE;
          grant_d = 1'b0;
        end
      endcase
    end

    start_d = '0;
    if (state_d == S_START) start_d[k_d] = 1'b1;
    busy_d      = (state_d != S_IDLE) && (state_d != S_ERR);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    err_layer_d = (state_d == S_ERR) ? k_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      grant_q     <= 1'b0;
      wdog_q      <= '0;
      start_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_layer_q <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      grant_q     <= grant_d;
      wdog_q      <= wdog_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_layer_q <= err_layer_d;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign err_layer_o   = err_layer_q;
  assign cur_layer_o   = k_q;
  assign layer_start_o = start_q;

  // Shared RAM port mux; nothing passes without a valid grant
  always_comb begin
    ram_addr_w_o = '0;
    ram_data_w_o = '0;
    ram_en_o     = 1'b0;
    ram_wea_o    = 1'b0;
    ram_addr_r_o = '0;
    ram_en_r_o   = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (grant_q && (k_q == LW'(i))) begin
        ram_addr_w_o = ram_addr_w_i[i*AW +: AW];
        ram_data_w_o = ram_data_w_i[i*DW +: DW];
        ram_en_o     = ram_en_i[i];
        ram_wea_o    = ram_wea_i[i];
        ram_addr_r_o = ram_addr_r_i[i*AW +: AW];
        ram_en_r_o   = ram_en_r_i[i];
      end
    end
  end

endmodule

// File: tb/tb_layer_sequencer.sv
// Scoreboard bench for layer_sequencer: engine models drive end levels, expected
// start/done events are queued with their due cycle and matched on observation.
module tb_layer_sequencer;

  localparam int unsigned NL = 4;
  localparam int unsigned LW = 2;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned TW = 20;
  localparam int unsigned TIMEOUT = 100;

  logic             clk;
  logic             rst_n;
  logic             run_i;
  logic             abort_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [LW-1:0]    err_layer_o;
  logic [LW-1:0]    cur_layer_o;
  logic [NL-1:0]    layer_start_o;
  logic [NL-1:0]    layer_end_i;
  logic [NL*AW-1:0] ram_addr_w_i;
  logic [NL*DW-1:0] ram_data_w_i;
  logic [NL-1:0]    ram_en_i;
  logic [NL-1:0]    ram_wea_i;
  logic [NL*AW-1:0] ram_addr_r_i;
  logic [NL-1:0]    ram_en_r_i;
  logic [AW-1:0]    ram_addr_w_o;
  logic [DW-1:0]    ram_data_w_o;
  logic             ram_en_o;
  logic             ram_wea_o;
  logic [AW-1:0]    ram_addr_r_o;
  logic             ram_en_r_o;

  layer_sequencer #(
    .NL(NL), .LW(LW), .AW(AW), .DW(DW), .TW(TW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .run_i(run_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_layer_o(err_layer_o),
    .cur_layer_o(cur_layer_o), .layer_start_o(layer_start_o), .layer_end_i(layer_end_i),
    .ram_addr_w_i(ram_addr_w_i), .ram_data_w_i(ram_data_w_i), .ram_en_i(ram_en_i),
    .ram_wea_i(ram_wea_i), .ram_addr_r_i(ram_addr_r_i), .ram_en_r_i(ram_en_r_i),
    .ram_addr_w_o(ram_addr_w_o), .ram_data_w_o(ram_data_w_o), .ram_en_o(ram_en_o),
    .ram_wea_o(ram_wea_o), .ram_addr_r_o(ram_addr_r_o), .ram_en_r_o(ram_en_r_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [NL-1:0] start;
    logic          done;
  } ev_t;

  ev_t           sb_q[$];
  int            cyc;
  int            n_chk;
  int            n_pass;
  int            exp_k;
  bit            exp_active;
  int            exp_start_cyc[NL];
  int            eng_cnt[NL];
  logic [NL-1:0] hang;
  logic [NL-1:0] stale;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic push_ev(input int c, input logic [NL-1:0] s, input logic d);
    ev_t e;
    e.cyc = c;
    e.start = s;
    e.done = d;
    sb_q.push_back(e);
  endtask

  // One clock: score observed events, then advance the engine models
  task automatic tick();
    ev_t e;
    logic [NL-1:0] prev;
    logic [NL-1:0] nxt;
    @(posedge clk);
    #1;
    cyc++;
    if (layer_start_o != '0 || done_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_event", 32'({layer_start_o, done_o}), 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("event_start", 32'(layer_start_o), 32'(e.start));
        chk("event_done", 32'(done_o), 32'(e.done));
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      chk("missing_event", 32'({layer_start_o, done_o}), 32'({e.start, e.done}));
    end

    prev = layer_end_i;
    for (int i = 0; i < NL; i++) begin
      if (layer_start_o[i]) eng_cnt[i] = 1;
      else if (eng_cnt[i] != 0) eng_cnt[i] = (eng_cnt[i] >= 23) ? 0 : eng_cnt[i] + 1;
      nxt[i] = ((eng_cnt[i] >= 20) && !hang[i]) || stale[i];
    end
    layer_end_i = nxt;
    for (int i = 0; i < NL; i++) begin
      if (prev[i] && !nxt[i] && exp_active && i == exp_k) begin
        if (exp_k == NL - 1) begin
          push_ev(cyc + 1, '0, 1'b1);
          exp_active = 0;
        end else begin
          exp_k++;
          exp_start_cyc[exp_k] = cyc + 1;
          push_ev(cyc + 1, 4'(1 << exp_k), 1'b0);
        end
      end
    end
  endtask

  // Pulse run_i; the layer-0 start is scored during this tick
  task automatic start_run();
    run_i = 1'b1;
    exp_k = 0;
    exp_active = 1;
    exp_start_cyc[0] = cyc + 1;
    push_ev(cyc + 1, 4'b0001, 1'b0);
    tick();
    run_i = 1'b0;
  endtask

  task automatic wait_start(input int k, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (layer_start_o[k]) begin
        found = 1;
        break;
      end
    end
    chk("wait_start", 32'(found), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_o) begin
        found = 1;
        break;
      end
    end
    chk("wait_done", 32'(found), 32'd1);
  endtask

  task automatic wait_err(input int budget, output int ecyc);
    bit found;
    found = 0;
    ecyc = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (err_o) begin
        found = 1;
        ecyc = cyc;
        break;
      end
    end
    chk("wait_err", 32'(found), 32'd1);
  endtask

  task automatic chk_ram_idle(input string tag);
    chk({tag, "_addr_w"}, 32'(ram_addr_w_o), 32'd0);
    chk({tag, "_data_w"}, 32'(ram_data_w_o), 32'd0);
    chk({tag, "_en"}, 32'(ram_en_o), 32'd0);
    chk({tag, "_wea"}, 32'(ram_wea_o), 32'd0);
    chk({tag, "_addr_r"}, 32'(ram_addr_r_o), 32'd0);
    chk({tag, "_en_r"}, 32'(ram_en_r_o), 32'd0);
  endtask

  initial begin
    int s1;
    int ecyc;
    cyc = 0;
    n_chk = 0;
    n_pass = 0;
    exp_k = 0;
    exp_active = 0;
    hang = '0;
    stale = '0;
    rst_n = 1'b0;
    run_i = 1'b0;
    abort_i = 1'b0;
    layer_end_i = '0;
    for (int i = 0; i < NL; i++) begin
      eng_cnt[i] = 0;
      exp_start_cyc[i] = 0;
      ram_addr_w_i[i*AW +: AW] = 16'h1000 + 16'(i);
      ram_data_w_i[i*DW +: DW] = 8'h11 * 8'(i + 1);
      ram_addr_r_i[i*AW +: AW] = 16'hA000 + 16'(i);
    end
    ram_addr_w_i[2*AW +: AW] = 16'h0005;
    ram_data_w_i[2*DW +: DW] = 8'h80;
    ram_en_i   = 4'b1111;
    ram_wea_i  = 4'b0111;
    ram_en_r_i = 4'b1111;

    repeat (3) tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_err_layer", 32'(err_layer_o), 32'd0);
    chk("rst_cur_layer", 32'(cur_layer_o), 32'd0);
    chk("rst_start", 32'(layer_start_o), 32'd0);
    chk_ram_idle("rst_ram");
    rst_n = 1'b1;
    tick();

    // Full sequence with a stale end on layer 3 while layer 0 runs
    stale[3] = 1'b1;
    tick();
    start_run();
    chk("busy_running", 32'(busy_o), 32'd1);
    wait_start(1, 60);
    stale[3] = 1'b0;
    wait_start(2, 60);
    repeat (5) tick();
    chk("cur_layer2", 32'(cur_layer_o), 32'd2);
    chk("ram_addr_w_l2", 32'(ram_addr_w_o), 32'h0005);
    chk("ram_data_w_l2", 32'(ram_data_w_o), 32'h80);
    chk("ram_en_l2", 32'(ram_en_o), 32'd1);
    chk("ram_wea_l2", 32'(ram_wea_o), 32'd1);
    chk("ram_addr_r_l2", 32'(ram_addr_r_o), 32'hA002);
    chk("ram_en_r_l2", 32'(ram_en_r_o), 32'd1);
    wait_start(3, 60);
    repeat (5) tick();
    chk("ram_wea_l3", 32'(ram_wea_o), 32'd0);
    chk("ram_addr_w_l3", 32'(ram_addr_w_o), 32'h1003);
    wait_done(60);
    tick();
    chk("done_pulse_width", 32'(done_o), 32'd0);
    chk("busy_after_done", 32'(busy_o), 32'd0);
    chk_ram_idle("post_done_ram");
    repeat (10) tick();

    // Layer 1 hangs: watchdog fires, run ignored, abort recovers
    hang[1] = 1'b1;
    start_run();
    wait_start(1, 60);
    s1 = exp_start_cyc[1];
    wait_err(300, ecyc);
    chk("err_cycle", 32'(ecyc), 32'(s1 + 101));
    chk("err_layer", 32'(err_layer_o), 32'd1);
    chk("err_busy", 32'(busy_o), 32'd0);
    chk("err_cur_layer", 32'(cur_layer_o), 32'd1);
    chk("err_ram_en", 32'(ram_en_o), 32'd0);
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    repeat (3) tick();
    chk("err_hold", 32'(err_o), 32'd1);
    chk("err_run_ignored", 32'(busy_o), 32'd0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_clears_err", 32'(err_o), 32'd0);
    chk("abort_err_layer", 32'(err_layer_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    hang[1] = 1'b0;
    repeat (30) tick();

    // Abort in the same cycle layer 0's end rises
    start_run();
    repeat (19) tick();
    abort_i = 1'b1;
    exp_active = 0;
    tick();
    abort_i = 1'b0;
    chk("abort_busy0", 32'(busy_o), 32'd0);
    chk("abort_start0", 32'(layer_start_o), 32'd0);
    chk("abort_ram_en", 32'(ram_en_o), 32'd0);
    chk("abort_ram_en_r", 32'(ram_en_r_o), 32'd0);
    repeat (30) tick();
    chk("abort_still_idle", 32'(busy_o), 32'd0);

    // Asynchronous reset mid-run of layer 2, then a clean restart
    start_run();
    wait_start(2, 60);
    repeat (5) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy_o), 32'd0);
    chk("arst_cur_layer", 32'(cur_layer_o), 32'd0);
    chk("arst_start", 32'(layer_start_o), 32'd0);
    chk_ram_idle("arst_ram");
    sb_q.delete();
    exp_active = 0;
    for (int i = 0; i < NL; i++) eng_cnt[i] = 0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start_run();
    chk("restart_cur_layer", 32'(cur_layer_o), 32'd0);
    wait_start(1, 60);
    wait_start(2, 60);
    wait_start(3, 60);
    wait_done(60);
    tick();
    chk("restart_busy_after", 32'(busy_o), 32'd0);
    chk("leftover_events", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Top-level scheduler for the PL inference pipeline. Fires NL layer engines (e.g. CONV1, CONV2, FC1, FC2) strictly in order using their start/end handshakes.
- The layer engines share one intermediate-activation RAM. This block owns that RAM's write port and read-address port and muxes them to whichever layer currently holds the grant.
- Adds a per-layer watchdog, an abort path and busy/done/error status for the PS side.

Parameters:
NL, 4, number of layer engines sequenced (layer 0 runs first)
LW, 2, width of layer index (clog2(NL))
AW, 16, RAM address width
DW, 8, RAM data width (signed int8 activations)
TW, 20, watchdog counter width
TIMEOUT, 20'hFFFFF, max cycles a layer may spend in RUN+DRAIN; 0 disables watchdog

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
run_i  in  1  start network; sampled only in IDLE
abort_i  in  1  abort sequence; highest priority
busy_o  out  1  high in any state except IDLE/ERR
done_o  out  1  one-cycle pulse after last layer finished
err_o  out  1  watchdog fired; level, held in ERR
err_layer_o  out  LW  index of layer that timed out (valid while err_o)
cur_layer_o  out  LW  index of granted layer
layer_start_o  out  NL  one-hot start pulse to layer engines
layer_end_i  in  NL  per-layer end level (engine holds it high several cycles, then drops)
ram_addr_w_i  in  NL*AW  per-layer write address, layer k at [k*AW +: AW]
ram_data_w_i  in  NL*DW  per-layer write data
ram_en_i  in  NL  per-layer write-port enable
ram_wea_i  in  NL  per-layer write enable
ram_addr_r_i  in  NL*AW  per-layer read address
ram_en_r_i  in  NL  per-layer read enable
ram_addr_w_o  out  AW  shared RAM write address
ram_data_w_o  out  DW  shared RAM write data
ram_en_o  out  1  shared RAM write-port enable
ram_wea_o  out  1  shared RAM write enable
ram_addr_r_o  out  AW  shared RAM read address
ram_en_r_o  out  1  shared RAM read enable
(RAM read data is broadcast to all layers outside this block. ROM ports stay private per layer.)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE, layer index k=0, watchdog count=0, grant_valid=0; all outputs 0.
- States and transitions:
  - IDLE: if run_i → START with k=0, grant_valid=1.
  - START: layer_start_o[k]=1 for exactly this one cycle → RUN. Clear watchdog.
  - RUN: wait for layer_end_i[k]==1 (level) → DRAIN.
  - DRAIN: wait for layer_end_i[k]==0. Then, if k==NL-1 → DONE; else k←k+1 → START.
  - DONE: done_o=1 for one cycle, grant_valid←0 → IDLE.
  - ERR: err_o=1, err_layer_o=k, grant_valid=0. Leaves only on abort_i → IDLE, which clears err_o. run_i is ignored in ERR.
- Latency: run_i in cycle t gives layer_start_o[0] in cycle t+1. Layer k's end falling edge in cycle t gives layer_start_o[k+1] in cycle t+1, so there is one START cycle between layers.
- Watchdog:
  - Increments every cycle in RUN and DRAIN.
  - When count==TIMEOUT-1 and the state is still RUN/DRAIN → ERR next cycle.
  - Count saturates (never wraps). TIMEOUT=0 disables it.
- Abort: abort_i in any state → IDLE next cycle, grant_valid←0, layer_start_o=0. Layers are not reset; their RAM traffic is gated off.
- Priority for simultaneous events: abort_i > watchdog > layer_end_i.
- layer_end_i bits of non-granted layers are ignored, including a stale high.
- RAM mux is combinational from the registered k and grant_valid, with no added latency. With grant_valid=1, all shared outputs = layer k's inputs. With grant_valid=0, all shared outputs = 0. Enables of non-granted layers never reach the RAM.
- cur_layer_o = k in every state. busy_o = (state not in {IDLE, ERR}).

Test Plan:
1. NL=4, each engine model asserts end 20 cycles after start and holds it 4 cycles; pulse run_i → layer_start_o = 0001, 0010, 0100, 1000, each one cycle wide and one cycle after the previous end falls; done_o pulses once; busy_o low afterwards.
2. During layer 2's RUN, drive layer 2 ram_en_i=1, wea=1, addr=16'h0005, data=8'h80, while layers 0, 1 and 3 drive other values → shared outputs show exactly 0005/80/1/1; after DONE all shared outputs = 0.
3. TIMEOUT=100, layer 1 never asserts end → err_o rises exactly 100 cycles after START exits; err_layer_o=1; busy_o=0; run_i ignored; abort_i → IDLE, err_o=0.
4. Assert abort_i in the same cycle layer_end_i[0] rises → next state IDLE, no layer_start_o[1] pulse, RAM enables 0.
5. Hold layer_end_i[3]=1 stale while layer 0 runs → no effect; sequence advances only on layer 0's end.
6. Deassert rst_n mid-RUN of layer 2 → all outputs 0 immediately (asynchronous), state IDLE; a new run_i restarts from layer 0.
